// File: rtl/fb_bram_arbiter.sv
// fb_bram_arbiter: shares one frame-buffer BRAM port between the display
// scan-out reader and the overlay writer. Reads own the port during active
// video, writes win during vertical blanking, and a starvation counter
// force-grants a waiting write during active video.
// Optional build macro ARB_STATS_EN adds per-frame read/stall statistics.
module fb_bram_arbiter #(
  parameter int unsigned ADDR_W       = 18,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              Vsync,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic              bram_en,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [23:0]       stat_rd_cnt,
  output logic [7:0]        stat_stall_max
`endif
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic {
    ST_ACTIVE = 1'b0,
    ST_VBLANK = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic               vs_q;
  logic [CNT_W-1:0]   starve_q, starve_d;
  logic               vs_fall, vs_rise;
  logic               force_wr;
  logic               rd_gnt_raw, wr_gnt_raw;
  logic               rd_xfer, wr_xfer;
  logic               enter_vblank;

  logic               bram_en_q, bram_we_q;
  logic [ADDR_W-1:0]  bram_addr_q;
  logic [DATA_W-1:0]  bram_wdata_q;
  logic               rd_pend_q, rd_valid_q;
  logic [DATA_W-1:0]  rd_hold_q;

  assign vs_fall = vs_q & ~Vsync;
  assign vs_rise = ~vs_q & Vsync;

  // State, sync history and starvation counter registers
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q  <= ST_ACTIVE;
      vs_q     <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      vs_q     <= Vsync;
      starve_q <= starve_d;
    end
  end

  // Arbitration, next state and starvation counter update
  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    force_wr     = 1'b0;
    rd_gnt_raw   = 1'b0;
    wr_gnt_raw   = 1'b0;
    enter_vblank = 1'b0;
    case (state_q)
      ST_ACTIVE: begin
        force_wr   = (starve_q == LIMIT);
        rd_gnt_raw = rd_req & ~force_wr;
        wr_gnt_raw = wr_req & (~rd_req | force_wr);
        if (wr_gnt_raw) begin
          starve_d = '0;
        end else if (wr_req && (starve_q != LIMIT)) begin
          starve_d = starve_q + CNT_W'(1);
        end
        if (vs_fall) begin
          state_d      = ST_VBLANK;
          enter_vblank = 1'b1;
          starve_d     = '0;
        end
      end
      ST_VBLANK: begin
        wr_gnt_raw = wr_req;
        rd_gnt_raw = rd_req & ~wr_req;
        if (wr_gnt_raw) begin
          starve_d = '0;
        end
        if (vs_rise) begin
          state_d = ST_ACTIVE;
        end
      end
      default: begin
        state_d = ST_ACTIVE;
      end
    endcase
  end

  // Grants are held low while reset is asserted so every output reads 0
  assign rd_gnt  = rd_gnt_raw & nRESET;
  assign wr_gnt  = wr_gnt_raw & nRESET;
  assign rd_xfer = rd_req & rd_gnt;
  assign wr_xfer = wr_req & wr_gnt;

  // BRAM port registers: one cycle after each transfer; addr/wdata hold when idle
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      bram_en_q    <= 1'b0;
      bram_we_q    <= 1'b0;
      bram_addr_q  <= '0;
      bram_wdata_q <= '0;
    end else begin
      bram_en_q <= rd_xfer | wr_xfer;
      bram_we_q <= wr_xfer;
      if (rd_xfer) begin
        bram_addr_q <= rd_addr;
      end else if (wr_xfer) begin
        bram_addr_q  <= wr_addr;
        bram_wdata_q <= wr_data;
      end
    end
  end

  // Read return pipeline: valid two cycles after the transfer, data held between pulses
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      rd_pend_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_hold_q  <= '0;
    end else begin
      rd_pend_q  <= rd_xfer;
      rd_valid_q <= rd_pend_q;
      if (rd_valid_q) begin
        rd_hold_q <= bram_rdata;
      end
    end
  end

  // BRAM read data arrives in the valid cycle itself, so pass it through then
  assign rd_data    = rd_valid_q ? bram_rdata : rd_hold_q;
  assign rd_valid   = rd_valid_q;
  assign bram_en    = bram_en_q;
  assign bram_we    = bram_we_q;
  assign bram_addr  = bram_addr_q;
  assign bram_wdata = bram_wdata_q;

`ifdef ARB_STATS_EN
  logic [23:0]      rd_run_q, rd_run_d;
  logic [CNT_W-1:0] stall_run_q, stall_run_d;
  logic [23:0]      stat_rd_q;
  logic [CNT_W-1:0] stat_stall_q;

  // Running frame counters including this cycle's activity, saturating
  always_comb begin
    rd_run_d    = rd_run_q;
    stall_run_d = stall_run_q;
    if (rd_xfer && (rd_run_q != '1)) begin
      rd_run_d = rd_run_q + 24'd1;
    end
    if (starve_q > stall_run_q) begin
      stall_run_d = starve_q;
    end
  end

  // Latch statistics at the start of vertical blanking, then restart counting
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      rd_run_q     <= '0;
      stall_run_q  <= '0;
      stat_rd_q    <= '0;
      stat_stall_q <= '0;
    end else if (enter_vblank) begin
      stat_rd_q    <= rd_run_d;
      stat_stall_q <= stall_run_d;
      rd_run_q     <= '0;
      stall_run_q  <= '0;
    end else begin
      rd_run_q    <= rd_run_d;
      stall_run_q <= stall_run_d;
    end
  end

  assign stat_rd_cnt    = stat_rd_q;
  assign stat_stall_max = stat_stall_q;
`endif

endmodule

// File: tb/tb_fb_bram_arbiter.sv
// Bench for fb_bram_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_fb_bram_arbiter;
  localparam int unsigned AW  = 18;
  localparam int unsigned DW  = 16;
  localparam int          LIM = 8;

  logic          CLK = 1'b0;
  logic          nRESET, Vsync, rd_req, wr_req;
  logic [AW-1:0] rd_addr, wr_addr, bram_addr;
  logic [DW-1:0] wr_data, rd_data, bram_wdata, bram_rdata;
  logic          rd_gnt, rd_valid, wr_gnt, bram_en, bram_we;
`ifdef ARB_STATS_EN
  logic [23:0]   stat_rd_cnt;
  logic [7:0]    stat_stall_max;
`endif

  fb_bram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .CLK(CLK), .nRESET(nRESET), .Vsync(Vsync),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .bram_rdata(bram_rdata)
`ifdef ARB_STATS_EN
    , .stat_rd_cnt(stat_rd_cnt), .stat_stall_max(stat_stall_max)
`endif
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] init_val(input int i);
    if (i == 16) return 16'hBEEF;
    if (i < 4) return 16'(16'hA000 + i);
    return 16'((i * 291) ^ 16'h5A5A);
  endfunction

  // BRAM model: 1-cycle synchronous read, contents seeded on the first edge
  logic [15:0] mem [0:1023];
  bit mem_ready = 1'b0;
  always @(posedge CLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (bram_en) begin
      if (bram_we) mem[bram_addr[9:0]] <= bram_wdata;
      else         bram_rdata <= mem[bram_addr[9:0]];
    end
  end

  // Behavioural model state
  int            cyc = 0;
  bit            m_vb, m_vsq;
  int            m_starve;
  logic          e_en, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rdlast;
  logic [15:0]   shadow [0:1023];
  bit            shadow_ready = 1'b0;
  int            due_q[$];
  logic [15:0]   dat_q[$];
  int            m_rdcnt, m_stallrun, e_stat_rd, e_stat_stall;

  // Per-cycle compare against the model, then advance the model by one cycle
  always @(negedge CLK) begin
    bit eg_rd, eg_wr, frc, fall, rise, e_valid;
    if (!shadow_ready) begin
      for (int i = 0; i < 1024; i++) shadow[i] = init_val(i);
      shadow_ready = 1'b1;
    end
    cyc++;
    if (!nRESET) begin
      m_vb = 0; m_vsq = 0; m_starve = 0;
      e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_rdlast = '0;
      due_q.delete(); dat_q.delete();
      m_rdcnt = 0; m_stallrun = 0; e_stat_rd = 0; e_stat_stall = 0;
      check("rst_rd_gnt", 32'(rd_gnt), 32'd0);
      check("rst_wr_gnt", 32'(wr_gnt), 32'd0);
      check("rst_bram_en", 32'(bram_en), 32'd0);
      check("rst_bram_we", 32'(bram_we), 32'd0);
      check("rst_bram_addr", 32'(bram_addr), 32'd0);
      check("rst_bram_wdata", 32'(bram_wdata), 32'd0);
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_rd_data", 32'(rd_data), 32'd0);
    end else begin
      if (!m_vb) begin
        frc   = (m_starve == LIM);
        eg_rd = rd_req && !frc;
        eg_wr = wr_req && (!rd_req || frc);
      end else begin
        eg_wr = wr_req;
        eg_rd = rd_req && !wr_req;
      end
      check("rd_gnt", 32'(rd_gnt), 32'(eg_rd));
      check("wr_gnt", 32'(wr_gnt), 32'(eg_wr));
      check("bram_en", 32'(bram_en), 32'(e_en));
      check("bram_we", 32'(bram_we), 32'(e_we));
      check("bram_addr", 32'(bram_addr), 32'(e_addr));
      check("bram_wdata", 32'(bram_wdata), 32'(e_wdata));
      e_valid = (due_q.size() > 0) && (due_q[0] == cyc);
      if (e_valid) begin
        e_rdlast = dat_q[0];
        void'(due_q.pop_front());
        void'(dat_q.pop_front());
      end
      check("rd_valid", 32'(rd_valid), 32'(e_valid));
      check("rd_data", 32'(rd_data), 32'(e_rdlast));
`ifdef ARB_STATS_EN
      check("stat_rd_cnt", 32'(stat_rd_cnt), 32'(e_stat_rd));
      check("stat_stall_max", 32'(stat_stall_max), 32'(e_stat_stall));
`endif
      // Transfers in this cycle become port activity next cycle
      if (eg_rd) begin
        e_en = 1; e_we = 0; e_addr = rd_addr;
        due_q.push_back(cyc + 2);
        dat_q.push_back(shadow[rd_addr[9:0]]);
      end else if (eg_wr) begin
        e_en = 1; e_we = 1; e_addr = wr_addr; e_wdata = wr_data;
        shadow[wr_addr[9:0]] = wr_data;
      end else begin
        e_en = 0; e_we = 0;
      end
      fall = m_vsq && !Vsync;
      rise = !m_vsq && Vsync;
      if (m_starve > m_stallrun) m_stallrun = m_starve;
      if (eg_rd) m_rdcnt++;
      if (!m_vb) begin
        if (fall || eg_wr) m_starve = 0;
        else if (wr_req)   m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
        if (fall) begin
          m_vb = 1;
          e_stat_rd = m_rdcnt; e_stat_stall = m_stallrun;
          m_rdcnt = 0; m_stallrun = 0;
        end
      end else begin
        if (eg_wr) m_starve = 0;
        if (rise) m_vb = 0;
      end
      m_vsq = Vsync;
    end
  end

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Stimulus: directed scenarios, then randomized traffic across several frames
  initial begin
    int n_rd, wr_at, rd_after;
    bit gr, gw;
    nRESET = 0; Vsync = 1; rd_req = 0; wr_req = 0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    repeat (3) @(posedge CLK);
    #1 nRESET = 1;
    next_cycle();

    // Single read of 0x10 returning 0xBEEF
    rd_req = 1; rd_addr = AW'(18'h00010);
    @(negedge CLK); check("t3_gnt", 32'(rd_gnt), 32'd1);
    next_cycle(); rd_req = 0;
    @(negedge CLK);
    check("t3_en", 32'(bram_en), 32'd1);
    check("t3_we", 32'(bram_we), 32'd0);
    check("t3_addr", 32'(bram_addr), 32'h10);
    @(negedge CLK);
    check("t3_valid", 32'(rd_valid), 32'd1);
    check("t3_data", 32'(rd_data), 32'hBEEF);
    next_cycle();

    // Burst of four reads at 0..3, returns back to back in order
    for (int i = 0; i < 6; i++) begin
      rd_req = (i < 4); rd_addr = AW'(i);
      @(negedge CLK);
      if (i >= 2) begin
        check("t5_valid", 32'(rd_valid), 32'd1);
        check("t5_data", 32'(rd_data), 32'(16'hA000 + 16'(i - 2)));
      end
      next_cycle();
    end
    rd_req = 0;
    repeat (2) next_cycle();

    // Starvation: eight reads, one forced write, then reads resume
    rd_req = 1; rd_addr = AW'(18'h30); wr_req = 1; wr_addr = AW'(18'h20); wr_data = 16'h5555;
    n_rd = 0; wr_at = -1; rd_after = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      gw = wr_gnt;
      if (rd_gnt) n_rd++;
      if (gw && wr_at < 0) wr_at = c;
      if (c == 9) rd_after = 32'(rd_gnt);
      next_cycle();
      if (gw) wr_req = 0;
    end
    check("t2_wr_cycle", 32'(wr_at), 32'd8);
    check("t2_rd_count", 32'(n_rd), 32'd11);
    check("t2_rd_resume", 32'(rd_after), 32'd1);
    rd_req = 0; wr_req = 0;
    next_cycle();

    // Vsync fall hands priority to writes; rise returns it to reads
    rd_req = 1; wr_req = 1; Vsync = 0;
    @(negedge CLK);
    check("t4_fall_rd", 32'(rd_gnt), 32'd1);
    next_cycle();
    @(negedge CLK);
    check("t4_vb_wr", 32'(wr_gnt), 32'd1);
    check("t4_vb_rd", 32'(rd_gnt), 32'd0);
    repeat (3) next_cycle();
    Vsync = 1;
    @(negedge CLK);
    check("t4_rise_wr", 32'(wr_gnt), 32'd1);
    next_cycle();
    @(negedge CLK);
    check("t4_act_rd", 32'(rd_gnt), 32'd1);
    check("t4_act_wr", 32'(wr_gnt), 32'd0);
    next_cycle();
    rd_req = 0; wr_req = 0;
    repeat (3) next_cycle();

    // Reset arriving one cycle after a read grant suppresses its return
    rd_req = 1; rd_addr = AW'(18'h5);
    @(negedge CLK); check("t1_gnt", 32'(rd_gnt), 32'd1);
    next_cycle();
    rd_req = 0; nRESET = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("t1_no_valid", 32'(rd_valid), 32'd0);
      check("t1_en", 32'(bram_en), 32'd0);
      next_cycle();
    end
    nRESET = 1;
    next_cycle();

    // Randomized traffic with proper hold-until-granted requesters
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLK);
      gr = rd_gnt; gw = wr_gnt;
      next_cycle();
      if (rd_req && gr) rd_req = 0;
      if (wr_req && gw) wr_req = 0;
      if (!rd_req && ($urandom_range(0, 99) < ((i < 2000) ? 92 : 40))) begin
        rd_req = 1; rd_addr = AW'($urandom_range(0, 1023));
      end
      if (!wr_req && ($urandom_range(0, 99) < 50)) begin
        wr_req = 1; wr_addr = AW'($urandom_range(0, 1023)); wr_data = DW'($urandom);
      end
      Vsync = ((i % 230) < 200);
    end
    rd_req = 0; wr_req = 0; Vsync = 1;
    repeat (6) next_cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
